// File: rtl/hsiao_64_scrub_ctrl.sv
// Background ECC scrubber: reads each 72-bit word, decodes it, writes back corrected words and counts errors.
// Latency: INTERVAL idle cycles, one read cycle, at least two decode cycles, then writeback until ack, then one NEXT cycle.
// Backpressure: waits while i_mem_busy is high, waits for i_dec_valid, and holds writeback until i_wb_ack.
// Optional macro SCRUB_FATAL_LOG_EN: latch the first fatal address on o_fatal_addr (otherwise o_fatal_addr is tied to 0).
module hsiao_64_scrub_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int INTERVAL = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              i_mem_busy,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [71:0]       i_mem_rdata,
  output logic              o_dec_en,
  output logic [71:0]       o_dec_code,
  input  logic              i_dec_valid,
  input  logic [63:0]       i_dec_data,
  input  logic              i_dec_err_corr,
  input  logic              i_dec_err_detec,
  input  logic              i_dec_err_fatal,
  output logic              o_wb_req,
  output logic [63:0]       o_wb_data,
  input  logic              i_wb_ack,
  output logic [15:0]       o_corr_cnt,
  output logic [15:0]       o_fatal_cnt,
  output logic [ADDR_W-1:0] o_fatal_addr,
  output logic              o_busy,
  output logic              o_pass_done
);

  localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(INTERVAL - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, WAIT, READ, DECODE, WB, NEXT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             fatal_hit;

  // A decoder result is only taken once the codeword has been presented (o_dec_en high).
  // Fatal wins over correctable so an uncorrectable word is never written back.
  assign fatal_hit = (state == DECODE) && o_dec_en && i_dec_valid &&
                     (i_dec_err_fatal || (i_dec_err_detec && !i_dec_err_corr));

  // Scrub FSM with registered outputs; o_mem_addr doubles as the scrub address register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      o_mem_rd    <= 1'b0;
      o_mem_addr  <= '0;
      o_dec_en    <= 1'b0;
      o_dec_code  <= '0;
      o_wb_req    <= 1'b0;
      o_wb_data   <= '0;
      o_corr_cnt  <= '0;
      o_fatal_cnt <= '0;
      o_busy      <= 1'b0;
      o_pass_done <= 1'b0;
    end else begin
      o_mem_rd    <= 1'b0;
      o_pass_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        WAIT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!i_mem_busy) begin
            state    <= READ;
            o_mem_rd <= 1'b1;
            o_busy   <= 1'b1;
          end
        end
        READ: begin
          state <= DECODE;
        end
        DECODE: begin
          if (!o_dec_en) begin
            // Read data is valid in the first DECODE cycle; capture it and present it.
            o_dec_code <= i_mem_rdata;
            o_dec_en   <= 1'b1;
          end else if (i_dec_valid) begin
            o_dec_en <= 1'b0;
            if (fatal_hit) begin
              if (o_fatal_cnt != 16'hFFFF) o_fatal_cnt <= o_fatal_cnt + 16'd1;
              state <= NEXT;
            end else if (i_dec_err_corr) begin
              if (o_corr_cnt != 16'hFFFF) o_corr_cnt <= o_corr_cnt + 16'd1;
              o_wb_data <= i_dec_data;
              o_wb_req  <= 1'b1;
              state     <= WB;
            end else begin
              state <= NEXT;
            end
          end
        end
        WB: begin
          if (i_wb_ack) begin
            o_wb_req <= 1'b0;
            state    <= NEXT;
          end
        end
        NEXT: begin
          if (o_mem_addr == LAST_ADDR) begin
            o_mem_addr  <= '0;
            o_pass_done <= 1'b1;
          end else begin
            o_mem_addr <= o_mem_addr + 1'b1;
          end
          o_busy <= 1'b0;
          if (enable) begin
            state <= WAIT;
            cnt   <= CNT_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCRUB_FATAL_LOG_EN
  logic fatal_seen;

  // Keep the address of the first fatal word since reset; later fatals leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      fatal_seen   <= 1'b0;
      o_fatal_addr <= '0;
    end else if (fatal_hit && !fatal_seen) begin
      fatal_seen   <= 1'b1;
      o_fatal_addr <= o_mem_addr;
    end
  end
`else
  assign o_fatal_addr = '0;
`endif

endmodule

// File: doc/hsiao_64_scrub_ctrl.md
HSIAO_64_SCRUB_CTRL -- requirements
Module: hsiao_64_scrub_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory address width.
REQ-002 SHALL have parameter DEPTH, default 1024, number of 72-bit words scrubbed per pass; 2 <= DEPTH <= 2**ADDR_W.
REQ-003 SHALL have parameter INTERVAL, default 256, idle cycles between scrub reads; minimum 1.
REQ-004 SHALL have ports, clock and reset first:
  clk  in  1  rising-edge clock, only clock;
  reset  in  1  synchronous, active-high reset;
  enable  in  1  scrub enable;
  i_mem_busy  in  1  host owns memory port this cycle;
  o_mem_rd  out  1  one-cycle read strobe;
  o_mem_addr  out  ADDR_W  read/writeback address;
  i_mem_rdata  in  72  codeword, valid the cycle after o_mem_rd;
  o_dec_en  out  1  decoder enable;
  o_dec_code  out  72  codeword to decoder;
  i_dec_valid  in  1  decoder result valid;
  i_dec_data  in  64  corrected data;
  i_dec_err_corr, i_dec_err_detec, i_dec_err_fatal  in  1 each  decoder status;
  o_wb_req  out  1  writeback request;
  o_wb_data  out  64  corrected data for re-encode/write;
  i_wb_ack  in  1  writeback accepted;
  o_corr_cnt  out  16  corrected-error count;
  o_fatal_cnt  out  16  uncorrectable-error count;
  o_fatal_addr  out  ADDR_W  first fatal address;
  o_busy  out  1  FSM not in IDLE/WAIT;
  o_pass_done  out  1  one-cycle pulse at end of pass.

Function
REQ-005 SHALL implement FSM states IDLE, WAIT, READ, DECODE, WB, NEXT.
REQ-006 IDLE -> WAIT when enable=1; interval counter loaded with INTERVAL-1.
REQ-007 WAIT SHALL decrement counter each cycle; at 0 and i_mem_busy=0 -> READ; at 0 with i_mem_busy=1 SHALL hold until i_mem_busy=0.
REQ-008 READ SHALL assert o_mem_rd for exactly one cycle with o_mem_addr = current scrub address, then -> DECODE.
REQ-009 DECODE SHALL capture i_mem_rdata into o_dec_code on entry, assert o_dec_en until i_dec_valid=1, then sample status bits.
REQ-010 On i_dec_valid with err_corr=1 SHALL increment o_corr_cnt, latch i_dec_data into o_wb_data, -> WB.
REQ-011 On i_dec_valid with err_fatal=1 (or err_detec=1 and err_corr=0) SHALL increment o_fatal_cnt, no writeback, -> NEXT.
REQ-012 On i_dec_valid with no error flag SHALL -> NEXT directly.
REQ-013 WB SHALL hold o_wb_req=1, o_wb_data and o_mem_addr stable until i_wb_ack=1; ack in the first WB cycle is legal; then -> NEXT.
REQ-014 NEXT SHALL increment address; at DEPTH-1 SHALL wrap to 0 and pulse o_pass_done for one cycle; then -> WAIT if enable=1, else IDLE.
REQ-015 Counters SHALL saturate at 16'hFFFF.
REQ-016 enable deassert SHALL be honoured only in IDLE/WAIT/NEXT; an in-flight READ/DECODE/WB SHALL complete first; address retained.
REQ-017 o_busy SHALL be 1 in READ, DECODE, WB, NEXT.

Reset
REQ-018 reset=1 at a clock edge SHALL force IDLE, address 0, all counters 0, and all outputs 0 the following cycle, aborting any operation including pending writeback.

Configuration
REQ-019 Macro SCRUB_FATAL_LOG_EN defined: o_fatal_addr SHALL capture the address of the first fatal error since reset and hold it; later fatals do not overwrite.
REQ-020 Macro undefined: o_fatal_addr SHALL be constant 0; o_fatal_cnt unaffected.

Verification
REQ-021 INTERVAL=4, DEPTH=4, clean data, decoder valid 1 cycle after o_dec_en -> reads at addr 0,1,2,3, o_pass_done pulse after addr 3, o_corr_cnt=0.
REQ-022 Addr 1 returns single-bit error (err_corr=1, data 64'h1234) -> o_wb_req with o_mem_addr=1, o_wb_data=64'h1234 held until ack after 3 cycles; o_corr_cnt=1.
REQ-023 Addr 2 returns err_fatal=1 -> no o_wb_req, o_fatal_cnt=1, o_fatal_addr=2 with macro, 0 without.
REQ-024 i_mem_busy=1 for 10 cycles when WAIT expires -> o_mem_rd delayed until first cycle after i_mem_busy=0.
REQ-025 reset asserted during WB with o_wb_req=1 -> next cycle o_wb_req=0, counters 0, state IDLE; next scrub starts at addr 0.
REQ-026 enable dropped during DECODE -> decode and any writeback complete, then IDLE; re-enable resumes at next address.
